// File: rtl/fir_fifo_reader.sv
// FIFO-fed sequential FIR: pops one sample, runs N_TAPS MAC cycles,
// then emits one saturated filtered sample with a one-cycle strobe.
module fir_fifo_reader #(
    parameter int N_TAPS     = 16,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int ACC_W      = 40,
    parameter int RD_LATENCY = 1,
    parameter int SHIFT      = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      empty_i,
    input  logic [DATA_W-1:0]         dato_i,
    output logic                      rd_en_o,
    input  logic                      coef_we_i,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr_i,
    input  logic [COEF_W-1:0]         coef_i,
    output logic [DATA_W-1:0]         dato_o,
    output logic                      valid_o,
    output logic                      sat_o,
    output logic                      busy_o
);

    localparam int ADDR_W = $clog2(N_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int WCNT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SHIFT,
        S_MAC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] k_q, k_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic signed [DATA_W-1:0] x_q [N_TAPS];
    logic signed [DATA_W-1:0] x_d [N_TAPS];
    logic signed [COEF_W-1:0] c_q [N_TAPS];
    logic signed [COEF_W-1:0] c_d [N_TAPS];

    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic [DATA_W-1:0] dato_q, dato_d;
    logic              valid_q, valid_d;
    logic              sat_q, sat_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic                     last_tap;
    logic                     fits;
    logic [DATA_W-1:0]        sat_val;

    assign prod     = x_q[k_q] * c_q[k_q];
    assign mac_sum  = acc_q + ACC_W'(prod);
    assign shifted  = mac_sum >>> SHIFT;
    assign last_tap = (k_q == ADDR_W'(N_TAPS - 1));

    // Result fits when every bit above the output sign bit matches it.
    assign fits = (&shifted[ACC_W-1:DATA_W-1]) |
                  (~|shifted[ACC_W-1:DATA_W-1]);

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (!fits) begin
            if (shifted[ACC_W-1]) begin
                sat_val = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sat_val = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wcnt_d  = wcnt_q;
        x_d     = x_q;
        c_d     = c_q;
        acc_d   = acc_q;
        dato_d  = dato_q;
        valid_d = 1'b0;
        sat_d   = 1'b0;

        if ((state_q == S_IDLE) && coef_we_i) begin
            c_d[coef_addr_i] = coef_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (enable_i && !empty_i) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                wcnt_d  = '0;
                state_d = (RD_LATENCY == 1) ? S_SHIFT : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == WCNT_W'(RD_LATENCY - 2)) begin
                    state_d = S_SHIFT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                for (int i = N_TAPS - 1; i > 0; i--) begin
                    x_d[i] = x_q[i-1];
                end
                x_d[0]  = dato_i;
                acc_d   = '0;
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = mac_sum;
                k_d   = k_q + 1'b1;
                // Result registers on the final MAC edge so dato_o is
                // already valid during the OUT strobe cycle.
                if (last_tap) begin
                    dato_d  = sat_val;
                    valid_d = 1'b1;
                    sat_d   = ~fits;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            wcnt_q  <= '0;
            acc_q   <= '0;
            dato_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            dato_q  <= dato_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            x_q     <= x_d;
            c_q     <= c_d;
        end
    end

    assign rd_en_o = (state_q == S_READ);
    assign busy_o  = (state_q != S_IDLE);
    assign dato_o  = dato_q;
    assign valid_o = valid_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_fir_fifo_reader.sv
// Scoreboard bench for fir_fifo_reader: FIFO model drives samples,
// a monitor pops expected results on every valid_o strobe.
module tb_fir_fifo_reader;

    localparam int N   = 16;
    localparam int LAT = 18;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        empty_i;
    logic [15:0] dato_i;
    logic        rd_en_o;
    logic        coef_we_i;
    logic [3:0]  coef_addr_i;
    logic [15:0] coef_i;
    logic [15:0] dato_o;
    logic        valid_o;
    logic        sat_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    fir_fifo_reader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .empty_i     (empty_i),
        .dato_i      (dato_i),
        .rd_en_o     (rd_en_o),
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_i      (coef_i),
        .dato_o      (dato_o),
        .valid_o     (valid_o),
        .sat_o       (sat_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        int val;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   fifo_q[$];
    int   rd_cyc_q[$];
    int   cyc = 0;
    int   rd_total = 0;
    int   checks = 0;
    int   fails = 0;
    int   m_x[N];
    int   m_c[N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // FIFO model: data appears mid-READ, stable through SHIFT.
    always @(negedge clk_i) begin
        if (rd_en_o) begin
            check("rd_while_nonempty", int'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) dato_i = 16'(fifo_q.pop_front());
            rd_cyc_q.push_back(cyc);
            rd_total++;
        end
        empty_i = (fifo_q.size() == 0);
    end

    // Monitor / scoreboard.
    always @(negedge clk_i) begin
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: got dato %0d expected no strobe",
                         $signed(dato_o));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dato", int'($signed(dato_o)), e.val);
                check("sat", int'(sat_o), int'(e.sat));
                if (rd_cyc_q.size() != 0)
                    check("latency", cyc - rd_cyc_q.pop_front(), LAT);
            end
        end
    end

    task automatic model_push(input int s);
        for (int i = N - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = s;
    endtask

    task automatic model_exp(output int v, output bit s);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(m_x[i]) * longint'(m_c[i]);
        r = acc >>> 15;
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        v = int'(r);
    endtask

    task automatic feed_hand(input int s, input int e, input bit sat);
        model_push(s);
        exp_q.push_back('{val: e, sat: sat});
        fifo_q.push_back(s);
    endtask

    task automatic feed_model(input int s);
        int v;
        bit sat;
        model_push(s);
        model_exp(v, sat);
        exp_q.push_back('{val: v, sat: sat});
        fifo_q.push_back(s);
    endtask

    task automatic write_coef(input int a, input int v, input bit upd);
        @(negedge clk_i);
        coef_we_i   = 1'b1;
        coef_addr_i = 4'(a);
        coef_i      = 16'(v);
        if (upd) m_c[a] = v;
        @(negedge clk_i);
        coef_we_i = 1'b0;
    endtask

    // Called at a negedge; holds reset across exactly one rising edge.
    task automatic do_reset();
        rst_i     = 1'b0;
        coef_we_i = 1'b0;
        fifo_q.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        rd_cyc_q.delete();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0;
            m_c[i] = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_rd();
        int n;
        n = 0;
        while (!rd_en_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL read_timeout: got no rd_en_o expected one");
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dato"}, int'(dato_o), 0);
        check({tag, "_valid"}, int'(valid_o), 0);
        check({tag, "_sat"}, int'(sat_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_rd_en"}, int'(rd_en_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int rd0;
        bit busy_seen;
        rst_i       = 1'b0;
        enable_i    = 1'b1;
        empty_i     = 1'b1;
        dato_i      = '0;
        coef_we_i   = 1'b0;
        coef_addr_i = '0;
        coef_i      = '0;
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0;
            m_c[i] = 0;
        end
        repeat (3) @(negedge clk_i);
        check_zero_outputs("reset");
        rst_i = 1'b1;
        @(negedge clk_i);

        // Single-tap gain of one half.
        rd0 = rd_total;
        write_coef(0, 16384, 1);
        feed_hand(1000, 500, 0);
        feed_hand(-1000, -500, 0);
        drain();
        check("gain_reads", rd_total - rd0, 2);

        // Impulse response walks through the taps.
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, (k + 1) * 256, 1);
        feed_hand(16384, 128, 0);
        for (int k = 1; k < N; k++) feed_hand(0, (k + 1) * 128, 0);
        drain();

        // Saturation, both rails.
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, 32767, 1);
        for (int k = 0; k < N - 1; k++) feed_model(32767);
        feed_hand(32767, 32767, 1);
        for (int k = 0; k < N - 1; k++) feed_model(-32768);
        feed_hand(-32768, -32768, 1);
        drain();

        // Empty FIFO: no reads, never busy.
        do_reset();
        write_coef(0, 16384, 1);
        rd0 = rd_total;
        busy_seen = 1'b0;
        repeat (50) begin
            @(negedge clk_i);
            if (busy_o) busy_seen = 1'b1;
        end
        check("empty_no_read", rd_total - rd0, 0);
        check("empty_not_busy", int'(busy_seen), 0);

        // enable_i dropped mid-MAC: current sample completes, no new read.
        feed_hand(200, 100, 0);
        fifo_q.push_back(400);
        wait_rd();
        repeat (5) @(negedge clk_i);
        enable_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("enable_drop_reads", rd_total - rd0, 1);
        check("enable_drop_done", exp_q.size(), 0);
        check("enable_drop_left", fifo_q.size(), 1);
        fifo_q.delete();
        enable_i = 1'b1;

        // Coefficient write while busy is dropped.
        do_reset();
        write_coef(0, 16384, 1);
        feed_hand(1000, 500, 0);
        feed_hand(2000, 1000, 0);
        wait_rd();
        repeat (5) @(negedge clk_i);
        write_coef(0, 0, 0);
        drain();

        // Reset mid-MAC aborts the sample and clears the delay line.
        do_reset();
        write_coef(0, 16384, 1);
        write_coef(1, 16384, 1);
        fifo_q.push_back(3000);
        wait_rd();
        repeat (6) @(negedge clk_i);
        do_reset();
        check_zero_outputs("midreset");
        repeat (30) @(negedge clk_i);
        write_coef(0, 16384, 1);
        write_coef(1, 16384, 1);
        feed_hand(1000, 500, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
